// File: rtl/m68k_reg_responder_pkg.sv
// Shared definitions for the 68000-style register bus responder.
package m68k_reg_responder_pkg;

  // Bus cycle progress, from strobe decode through DTACK release.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STROBE,
    ST_ACCESS,
    ST_WAIT,
    ST_ACK,
    ST_RELEASE
  } state_t;

  // Value returned on the bus when the local register port never answers.
  localparam logic [15:0] READ_TIMEOUT_DATA = 16'hFFFF;

endpackage

// File: rtl/m68k_reg_responder_sync.sv
// N-stage synchroniser for an asynchronous bus strobe into the CLK40 domain.
module m68k_sync #(
  parameter int   N       = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic [N-1:0] r_sync;

  // Shift the raw strobe through the flop chain; reset to the negated level.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_sync <= {N{RST_VAL}};
    else       r_sync <= {r_sync[N-2:0], i_d};
  end

  assign o_q = r_sync[N-1];

endmodule

// File: rtl/m68k_reg_responder.sv
// Responder end of the 68000-style register bus: decodes strobes, runs the
// local register handshake and answers with nDTACK and read data.
module m68k_reg_responder
  import m68k_reg_responder_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int WAIT_STATES = 2,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 64
) (
  input  logic              CLK40,
  input  logic              RESET,
  input  logic              nCS,
  input  logic              nAS,
  input  logic              nUDS,
  input  logic              nLDS,
  input  logic              RnW,
  input  logic [ADDR_W:1]   A,
  input  logic [15:0]       D_IN,
  output logic [15:0]       D_OUT,
  output logic              D_OE,
  output logic              nDTACK,
  output logic [ADDR_W-1:0] REG_ADDR,
  output logic [15:0]       REG_WDATA,
  output logic [1:0]        REG_BE,
  output logic              REG_RD,
  output logic              REG_WR,
  input  logic [15:0]       REG_RDATA,
  input  logic              REG_READY,
  output logic              ERR
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int WW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
  localparam logic [WW-1:0] WS_LAST = WW'(WAIT_STATES - 1);

  logic w_as, w_uds, w_lds, w_cs;
  logic w_done;

  state_t            r_state,   n_state;
  logic              r_dtack_n, n_dtack_n;
  logic              r_oe,      n_oe;
  logic [15:0]       r_dout,    n_dout;
  logic              r_rd,      n_rd;
  logic              r_wr,      n_wr;
  logic [1:0]        r_be,      n_be;
  logic [ADDR_W-1:0] r_addr,    n_addr;
  logic [15:0]       r_wdata,   n_wdata;
  logic              r_rnw,     n_rnw;
  logic              r_err,     n_err;
  logic              r_abort,   n_abort;
  logic [TW-1:0]     r_tcnt,    n_tcnt;
  logic [WW-1:0]     r_wcnt,    n_wcnt;

  m68k_sync #(.N(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_as  (.i_clk(CLK40), .i_rst(RESET), .i_d(nAS),  .o_q(w_as));
  m68k_sync #(.N(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_uds (.i_clk(CLK40), .i_rst(RESET), .i_d(nUDS), .o_q(w_uds));
  m68k_sync #(.N(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_lds (.i_clk(CLK40), .i_rst(RESET), .i_d(nLDS), .o_q(w_lds));
  m68k_sync #(.N(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs  (.i_clk(CLK40), .i_rst(RESET), .i_d(nCS),  .o_q(w_cs));

  // Register the state and every bus/local-port output so nothing glitches.
  always_ff @(posedge CLK40 or posedge RESET) begin
    if (RESET) begin
      r_state   <= ST_IDLE;
      r_dtack_n <= 1'b1;
      r_oe      <= 1'b0;
      r_dout    <= '0;
      r_rd      <= 1'b0;
      r_wr      <= 1'b0;
      r_be      <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rnw     <= 1'b0;
      r_err     <= 1'b0;
      r_abort   <= 1'b0;
      r_tcnt    <= '0;
      r_wcnt    <= '0;
    end else begin
      r_state   <= n_state;
      r_dtack_n <= n_dtack_n;
      r_oe      <= n_oe;
      r_dout    <= n_dout;
      r_rd      <= n_rd;
      r_wr      <= n_wr;
      r_be      <= n_be;
      r_addr    <= n_addr;
      r_wdata   <= n_wdata;
      r_rnw     <= n_rnw;
      r_err     <= n_err;
      r_abort   <= n_abort;
      r_tcnt    <= n_tcnt;
      r_wcnt    <= n_wcnt;
    end
  end

  // Next-state and next-output decode for the bus cycle, from synced strobes only.
  always_comb begin
    n_state   = r_state;
    n_dtack_n = r_dtack_n;
    n_oe      = r_oe;
    n_dout    = r_dout;
    n_rd      = r_rd;
    n_wr      = r_wr;
    n_be      = r_be;
    n_addr    = r_addr;
    n_wdata   = r_wdata;
    n_rnw     = r_rnw;
    n_err     = 1'b0;
    n_abort   = r_abort;
    n_tcnt    = r_tcnt;
    n_wcnt    = r_wcnt;
    w_done    = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (!w_as && !w_cs) n_state = ST_STROBE;
      end

      ST_STROBE: begin
        if (w_as) begin
          n_state = ST_IDLE;
        end else if (!w_uds || !w_lds) begin
          // Write strobes lag nAS, so the cycle is latched on the first data strobe.
          n_addr  = A;
          n_rnw   = RnW;
          n_be    = {~w_uds, ~w_lds};
          n_wdata = D_IN;
          n_rd    = RnW;
          n_wr    = ~RnW;
          n_tcnt  = '0;
          n_abort = 1'b0;
          n_state = ST_ACCESS;
        end
      end

      ST_ACCESS: begin
        if (w_as) n_abort = 1'b1;
        if (REG_READY) begin
          n_rd   = 1'b0;
          n_wr   = 1'b0;
          if (r_rnw) n_dout = REG_RDATA;
          w_done = 1'b1;
        end else if (r_tcnt == TO_LAST) begin
          n_rd   = 1'b0;
          n_wr   = 1'b0;
          n_dout = READ_TIMEOUT_DATA;
          n_err  = 1'b1;
          w_done = 1'b1;
        end else begin
          n_tcnt = r_tcnt + TW'(1);
        end
        if (w_done) begin
          // A master that walked away gets no acknowledge, only a clean return to idle.
          if (r_abort || w_as) begin
            n_state = ST_IDLE;
          end else if (WAIT_STATES == 0) begin
            n_state   = ST_ACK;
            n_dtack_n = 1'b0;
            n_oe      = r_rnw;
          end else begin
            n_state = ST_WAIT;
            n_wcnt  = '0;
          end
        end
      end

      ST_WAIT: begin
        if (w_as) begin
          n_state = ST_IDLE;
        end else if (r_wcnt == WS_LAST) begin
          n_state   = ST_ACK;
          n_dtack_n = 1'b0;
          n_oe      = r_rnw;
        end else begin
          n_wcnt = r_wcnt + WW'(1);
        end
      end

      ST_ACK: begin
        if (w_as) begin
          n_state   = ST_RELEASE;
          n_dtack_n = 1'b1;
          n_oe      = 1'b0;
        end
      end

      ST_RELEASE: begin
        // Guaranteed dead cycle before a new strobe is honoured.
        n_state = ST_IDLE;
      end

      default: n_state = ST_IDLE;
    endcase
  end

  assign D_OUT     = r_dout;
  assign D_OE      = r_oe;
  assign nDTACK    = r_dtack_n;
  assign REG_ADDR  = r_addr;
  assign REG_WDATA = r_wdata;
  assign REG_BE    = r_be;
  assign REG_RD    = r_rd;
  assign REG_WR    = r_wr;
  assign ERR       = r_err;

endmodule

// File: tb/tb_m68k_reg_responder.sv
// Directed, table-driven bench for m68k_reg_responder.
`timescale 1ns/1ps
module tb_m68k_reg_responder;

  localparam int WS = 2;

  logic        CLK40 = 1'b0;
  logic        RESET = 1'b1;
  logic        nCS = 1'b1, nAS = 1'b1, nUDS = 1'b1, nLDS = 1'b1, RnW = 1'b1;
  logic [7:0]  A = '0;
  logic [15:0] D_IN = '0;
  logic [15:0] D_OUT;
  logic        D_OE, nDTACK;
  logic [7:0]  REG_ADDR;
  logic [15:0] REG_WDATA;
  logic [1:0]  REG_BE;
  logic        REG_RD, REG_WR;
  logic [15:0] REG_RDATA = '0;
  logic        REG_READY = 1'b0;
  logic        ERR;

  m68k_reg_responder #(.ADDR_W(8), .WAIT_STATES(WS), .SYNC_STAGES(2), .TIMEOUT(64)) dut (
    .CLK40(CLK40), .RESET(RESET), .nCS(nCS), .nAS(nAS), .nUDS(nUDS), .nLDS(nLDS),
    .RnW(RnW), .A(A), .D_IN(D_IN), .D_OUT(D_OUT), .D_OE(D_OE), .nDTACK(nDTACK),
    .REG_ADDR(REG_ADDR), .REG_WDATA(REG_WDATA), .REG_BE(REG_BE), .REG_RD(REG_RD),
    .REG_WR(REG_WR), .REG_RDATA(REG_RDATA), .REG_READY(REG_READY), .ERR(ERR)
  );

  always #12.5 CLK40 = ~CLK40;

  int checks = 0;
  int failures = 0;

  // Bus-level activity counters, sampled on the pre-edge values.
  int req_rises = 0, err_pulses = 0, dtack_cycles = 0, both_hi = 0, unstable = 0;
  logic        mon_prev_req = 1'b0;
  logic [25:0] mon_prev_lat = '0;

  always @(posedge CLK40) begin
    if ((REG_RD | REG_WR) && !mon_prev_req) req_rises <= req_rises + 1;
    if (ERR) err_pulses <= err_pulses + 1;
    if (!nDTACK) dtack_cycles <= dtack_cycles + 1;
    if (REG_RD && REG_WR) both_hi <= both_hi + 1;
    if (mon_prev_req && (REG_RD | REG_WR) && ({REG_ADDR, REG_BE, REG_WDATA} != mon_prev_lat))
      unstable <= unstable + 1;
    mon_prev_req <= REG_RD | REG_WR;
    mon_prev_lat <= {REG_ADDR, REG_BE, REG_WDATA};
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        cs_n;
    logic        rnw;
    logic        uds_n;
    logic        lds_n;
    logic [7:0]  addr;
    logic [15:0] din;
    int          strobe_dly;
    int          ready_dly;
    logic [15:0] rdata;
    logic [1:0]  exp_be;
    logic [15:0] exp_dout;
    int          post_idle;
  } vec_t;

  task automatic bus_release();
    nAS = 1'b1; nUDS = 1'b1; nLDS = 1'b1; nCS = 1'b1;
  endtask

  task automatic wait_req(input string tag, output logic seen);
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge CLK40);
      seen = REG_RD | REG_WR;
    end
    chk({tag, "_req_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic wait_dtack(input string tag, input logic level, output int lat);
    lat = 0;
    while (nDTACK !== level && lat < 100) begin
      @(negedge CLK40);
      lat++;
    end
    if (nDTACK !== level) chk({tag, "_dtack_wait"}, 32'(nDTACK), 32'(level));
  endtask

  task automatic run_txn(input vec_t v, input string tag);
    int   base_req, base_err, base_dt, lat;
    logic seen;
    base_req = req_rises; base_err = err_pulses; base_dt = dtack_cycles;
    @(negedge CLK40);
    A = v.addr; RnW = v.rnw; D_IN = v.din; nCS = v.cs_n; nAS = 1'b0;
    if (v.strobe_dly > 0) repeat (v.strobe_dly) @(negedge CLK40);
    nUDS = v.uds_n; nLDS = v.lds_n;
    if (v.cs_n) begin
      repeat (12) @(negedge CLK40);
      chk({tag, "_desel_noreq"}, 32'(req_rises - base_req), 32'd0);
      chk({tag, "_desel_nodtack"}, 32'(dtack_cycles - base_dt), 32'd0);
      bus_release();
      repeat (v.post_idle) @(negedge CLK40);
      return;
    end
    wait_req(tag, seen);
    if (!seen) begin
      bus_release();
      repeat (4) @(negedge CLK40);
      return;
    end
    chk({tag, "_rd"}, 32'(REG_RD), 32'(v.rnw));
    chk({tag, "_wr"}, 32'(REG_WR), 32'(!v.rnw));
    chk({tag, "_addr"}, 32'(REG_ADDR), 32'(v.addr));
    chk({tag, "_be"}, 32'(REG_BE), 32'(v.exp_be));
    chk({tag, "_wdata"}, 32'(REG_WDATA), 32'(v.din));
    if (v.ready_dly > 0) repeat (v.ready_dly) @(negedge CLK40);
    REG_RDATA = v.rdata; REG_READY = 1'b1;
    @(negedge CLK40);
    REG_READY = 1'b0;
    chk({tag, "_req_dropped"}, 32'(REG_RD | REG_WR), 32'd0);
    wait_dtack(tag, 1'b0, lat);
    chk({tag, "_ack_latency"}, 32'(lat + 1), 32'(WS + 1));
    chk({tag, "_oe_at_ack"}, 32'(D_OE), 32'(v.rnw));
    if (v.rnw) chk({tag, "_dout"}, 32'(D_OUT), 32'(v.exp_dout));
    bus_release();
    wait_dtack(tag, 1'b1, lat);
    chk({tag, "_oe_released"}, 32'(D_OE), 32'd0);
    if (v.rnw) chk({tag, "_dout_kept"}, 32'(D_OUT), 32'(v.exp_dout));
    chk({tag, "_one_req"}, 32'(req_rises - base_req), 32'd1);
    chk({tag, "_no_err"}, 32'(err_pulses - base_err), 32'd0);
    repeat (v.post_idle) @(negedge CLK40);
  endtask

  vec_t vecs[6];

  initial begin : main
    int   base_err, base_dt, n, lat;
    logic seen, oe_seen;

    //                cs   rnw  uds  lds  addr   din       sdly rdly rdata     be     dout      post
    vecs[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h12, 16'h0000, 0, 1, 16'hBEEF, 2'b11, 16'hBEEF, 2};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h21, 16'h00A5, 2, 1, 16'h0000, 2'b01, 16'h0000, 2};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h34, 16'h1357, 0, 0, 16'h5A00, 2'b10, 16'h5A00, 2};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, 16'h1234, 0, 3, 16'h0000, 2'b11, 16'h0000, 2};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h99, 16'h0000, 0, 0, 16'h0000, 2'b11, 16'h0000, 0};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h99, 16'h0000, 0, 0, 16'hC0DE, 2'b11, 16'hC0DE, 0};

    // Reset state.
    repeat (3) @(negedge CLK40);
    chk("rst_dtack", 32'(nDTACK), 32'd1);
    chk("rst_oe", 32'(D_OE), 32'd0);
    chk("rst_dout", 32'(D_OUT), 32'd0);
    chk("rst_req", 32'({REG_RD, REG_WR}), 32'd0);
    chk("rst_be", 32'(REG_BE), 32'd0);
    chk("rst_addr", 32'(REG_ADDR), 32'd0);
    chk("rst_wdata", 32'(REG_WDATA), 32'd0);
    chk("rst_err", 32'(ERR), 32'd0);
    RESET = 1'b0;
    repeat (2) @(negedge CLK40);

    for (int i = 0; i < 6; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    // Back-to-back: new strobe right after DTACK release.
    run_txn('{1'b0, 1'b1, 1'b0, 1'b0, 8'h3C, 16'h0000, 0, 0, 16'h0F0F, 2'b11, 16'h0F0F, 3}, "b2b");

    // Timeout: local port never answers a read.
    base_err = err_pulses;
    @(negedge CLK40);
    A = 8'h40; RnW = 1'b1; nCS = 1'b0; nAS = 1'b0; nUDS = 1'b0; nLDS = 1'b0;
    wait_req("to", seen);
    n = 0;
    while (ERR !== 1'b1 && n < 100) begin
      @(negedge CLK40);
      n++;
      if (n == 63) chk("to_rd_held", 32'(REG_RD), 32'd1);
    end
    chk("to_err_cycle", 32'(n), 32'd64);
    chk("to_rd_dropped", 32'(REG_RD), 32'd0);
    chk("to_dout", 32'(D_OUT), 32'hFFFF);
    @(negedge CLK40);
    chk("to_err_pulse", 32'(ERR), 32'd0);
    wait_dtack("to", 1'b0, lat);
    chk("to_oe", 32'(D_OE), 32'd1);
    chk("to_dout_ack", 32'(D_OUT), 32'hFFFF);
    bus_release();
    wait_dtack("to_rel", 1'b1, lat);
    chk("to_err_count", 32'(err_pulses - base_err), 32'd1);
    repeat (3) @(negedge CLK40);

    // Abort: master negates nAS during ACCESS, READY arrives later.
    base_err = err_pulses; base_dt = dtack_cycles;
    @(negedge CLK40);
    A = 8'h56; RnW = 1'b1; nCS = 1'b0; nAS = 1'b0; nUDS = 1'b0; nLDS = 1'b0;
    wait_req("ab", seen);
    @(negedge CLK40);
    bus_release();
    repeat (4) @(negedge CLK40);
    chk("ab_rd_still_high", 32'(REG_RD), 32'd1);
    REG_RDATA = 16'h1111; REG_READY = 1'b1;
    @(negedge CLK40);
    REG_READY = 1'b0;
    chk("ab_rd_dropped", 32'(REG_RD), 32'd0);
    oe_seen = D_OE;
    for (int k = 0; k < 15; k++) begin
      @(negedge CLK40);
      oe_seen |= D_OE;
    end
    chk("ab_no_dtack", 32'(dtack_cycles - base_dt), 32'd0);
    chk("ab_no_oe", 32'(oe_seen), 32'd0);
    chk("ab_no_err", 32'(err_pulses - base_err), 32'd0);
    run_txn('{1'b0, 1'b0, 1'b0, 1'b0, 8'h57, 16'hCAFE, 0, 0, 16'h0000, 2'b11, 16'h0000, 2}, "post_ab");

    // Reset while DTACK is asserted.
    @(negedge CLK40);
    A = 8'h77; RnW = 1'b1; nCS = 1'b0; nAS = 1'b0; nUDS = 1'b0; nLDS = 1'b0;
    wait_req("rs", seen);
    REG_RDATA = 16'h7777; REG_READY = 1'b1;
    @(negedge CLK40);
    REG_READY = 1'b0;
    wait_dtack("rs", 1'b0, lat);
    chk("rs_dtack_low", 32'(nDTACK), 32'd0);
    #2 RESET = 1'b1;
    #1;
    chk("rs_async_dtack", 32'(nDTACK), 32'd1);
    chk("rs_async_oe", 32'(D_OE), 32'd0);
    chk("rs_async_dout", 32'(D_OUT), 32'd0);
    @(negedge CLK40);
    RESET = 1'b0;
    bus_release();
    repeat (4) @(negedge CLK40);
    run_txn('{1'b0, 1'b1, 1'b0, 1'b0, 8'h78, 16'h0000, 0, 1, 16'hA55A, 2'b11, 16'hA55A, 2}, "post_rs");

    chk("mon_both_req", 32'(both_hi), 32'd0);
    chk("mon_latch_stable", 32'(unstable), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute guard against a hung run.
  initial begin
    #2000000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1, "global timeout");
  end

endmodule
